// File: rtl/fetch_queue.sv
// fetch_queue: owns the fetch PC, reads the combinational instruction ROM and
// buffers {pc, instr} pairs in a DEPTH-entry FIFO towards decode; redirect flushes and reloads.
`default_nettype none

module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [31:0]                rom_pc,
  input  logic [31:0]                rom_instr,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [63:0]   head_q, head_d;
  logic [63:0]   mem_q [DEPTH];
  logic          push, pop;
  logic          unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign rom_pc    = fetch_pc_q;
  assign out_valid = (occ_q != '0);
  assign out_pc    = head_q[63:32];
  assign out_instr = head_q[31:0];
  assign occupancy = occ_q;

  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = ~redirect_valid & ((occ_q < DEPTH_C) | pop);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    head_d     = head_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
      // The head register is the only path to decode; an empty queue keeps the last head.
      if (occ_d != '0) begin
        if (push && (wr_ptr_q == rd_ptr_d)) begin
          head_d = {fetch_pc_q, rom_instr};
        end else begin
          head_d = mem_q[rd_ptr_d];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      head_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {fetch_pc_q, rom_instr};
    end
  end

endmodule

`default_nettype wire
